// File: rtl/line_crop_if.sv
// line_crop_if: pixel-in / cropped-pixel-out bundle for line_crop.
// master drives pixels and observes the cropped stream; slave is the cropper.
interface line_crop_if;
  logic [23:0] data_i;
  logic        dataValid_i;
  logic [23:0] data_o;
  logic        dataValid_o;
  logic        line_done_o;
  logic        short_o;
  logic [11:0] line_len_o;

  modport master (
    output data_i, dataValid_i,
    input  data_o, dataValid_o, line_done_o, short_o, line_len_o
  );

  modport slave (
    input  data_i, dataValid_i,
    output data_o, dataValid_o, line_done_o, short_o, line_len_o
  );
endinterface

// File: rtl/line_crop.sv
// line_crop: forwards pixels [H_START, H_START+H_DISP) of each DVP line.
// Define LINE_CROP_STAT_EN to build the input line length register.
module line_crop #(
  parameter logic [11:0] H_DISP  = 12'd1280,
  parameter logic [11:0] H_START = 12'd0
) (
  input logic        clk,
  input logic        rst_n,
  line_crop_if.slave bus
);

  typedef enum logic [2:0] {
    SYNC, IDLE, SKIP, PASS, DROP
  } state_t;

  state_t      state, state_nx;
  logic [11:0] px_cnt, px_cnt_nx, px_inc;
  logic [11:0] out_cnt, out_cnt_nx, out_inc;
  logic        fwd, lend, v;

  assign v       = bus.dataValid_i;
  // px_cnt equals the index of the pixel now on data_i
  assign px_inc  = (px_cnt == 12'hFFF) ? px_cnt : px_cnt + 12'd1;
  assign out_inc = out_cnt + 12'd1;

  always_comb begin
    state_nx   = state;
    px_cnt_nx  = px_cnt;
    out_cnt_nx = out_cnt;
    fwd        = 1'b0;
    lend       = 1'b0;
    unique case (state)
      SYNC: begin
        if (!v) state_nx = IDLE;
      end
      IDLE: begin
        if (v) begin
          px_cnt_nx = 12'd1;
          if (H_START == 12'd0) begin
            fwd        = 1'b1;
            out_cnt_nx = 12'd1;
            state_nx   = (H_DISP == 12'd1) ? DROP : PASS;
          end else begin
            state_nx = SKIP;
          end
        end
      end
      SKIP: begin
        if (!v) begin
          lend = 1'b1;
        end else begin
          px_cnt_nx = px_inc;
          if (px_cnt == H_START) begin
            fwd        = 1'b1;
            out_cnt_nx = out_inc;
            state_nx   = (H_DISP == 12'd1) ? DROP : PASS;
          end
        end
      end
      PASS: begin
        if (!v) begin
          lend = 1'b1;
        end else begin
          px_cnt_nx  = px_inc;
          fwd        = 1'b1;
          out_cnt_nx = out_inc;
          if (out_inc == H_DISP) state_nx = DROP;
        end
      end
      DROP: begin
        if (!v) lend = 1'b1;
        else    px_cnt_nx = px_inc;
      end
      default: state_nx = SYNC;
    endcase
    if (lend) begin
      px_cnt_nx  = 12'd0;
      out_cnt_nx = 12'd0;
      state_nx   = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= SYNC;
      px_cnt  <= 12'd0;
      out_cnt <= 12'd0;
    end else begin
      state   <= state_nx;
      px_cnt  <= px_cnt_nx;
      out_cnt <= out_cnt_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.data_o      <= 24'h0;
      bus.dataValid_o <= 1'b0;
      bus.line_done_o <= 1'b0;
      bus.short_o     <= 1'b0;
    end else begin
      bus.data_o      <= fwd ? bus.data_i : 24'h0;
      bus.dataValid_o <= fwd;
      bus.line_done_o <= lend;
      bus.short_o     <= lend && (out_cnt < H_DISP);
    end
  end

`ifdef LINE_CROP_STAT_EN
  logic [11:0] line_len;

  always_ff @(posedge clk) begin
    if (!rst_n)    line_len <= 12'd0;
    else if (lend) line_len <= px_cnt;
  end

  assign bus.line_len_o = line_len;
`else
  assign bus.line_len_o = 12'd0;
`endif

endmodule

// File: tb/tb_line_crop.sv
// tb_line_crop: directed checks of line_crop with H_DISP=8, H_START=2.
// Expected line_len_o follows LINE_CROP_STAT_EN as built.
module tb_line_crop;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   stepn  = 0;
  int   ndone, last_short, zero_bad, short_bad, s0;
  logic [23:0] got[$];
  int          got_step[$];

`ifdef LINE_CROP_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  line_crop_if bus ();

  line_crop #(
    .H_DISP (12'd8),
    .H_START(12'd2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    got.delete();
    got_step.delete();
    ndone      = 0;
    last_short = -1;
    zero_bad   = 0;
    short_bad  = 0;
  endtask

  // apply one input cycle; outputs sampled reflect that cycle's input
  task automatic step(input logic vld, input logic [23:0] d);
    bus.dataValid_i = vld;
    bus.data_i      = d;
    @(posedge clk);
    #1;
    stepn++;
    if (bus.dataValid_o) begin
      got.push_back(bus.data_o);
      got_step.push_back(stepn);
    end else if (bus.data_o !== 24'h0) begin
      zero_bad++;
    end
    if (bus.line_done_o) begin
      ndone++;
      last_short = int'(bus.short_o);
    end else if (bus.short_o !== 1'b0) begin
      short_bad++;
    end
  endtask

  task automatic line(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      if (i == 0) s0 = stepn + 1;
      step(1'b1, 24'(base + i));
    end
    step(1'b0, 24'h0);
  endtask

  task automatic chk_px(input string tag, input int first, input int n);
    chk({tag, "_cnt"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++)
      chk({tag, "_px"}, int'(got[i]), first + i);
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.dataValid_i = 1'b0;
    bus.data_i      = 24'h0;
    clr();
    step(1'b0, 24'h0);
    step(1'b0, 24'h0);
    chk("rst_data", int'(bus.data_o), 0);
    chk("rst_dv", int'(bus.dataValid_o), 0);
    chk("rst_done", int'(bus.line_done_o), 0);
    chk("rst_short", int'(bus.short_o), 0);
    chk("rst_len", int'(bus.line_len_o), 0);
    rst_n = 1'b1;
    step(1'b0, 24'h0);

    // 12-pixel line: pixels 3..10, first out one cycle after index 2
    clr();
    line(12, 1);
    chk_px("l12", 3, 8);
    if (got_step.size() == 8) begin
      chk("l12_lat", got_step[0] - s0, 2);
      chk("l12_span", got_step[7] - got_step[0], 7);
    end
    chk("l12_done", ndone, 1);
    chk("l12_short", last_short, 0);
    chk("l12_len", int'(bus.line_len_o), STAT ? 12 : 0);
    chk("l12_zero", zero_bad + short_bad, 0);

    // short line of 6
    clr();
    line(6, 1);
    chk_px("l6", 3, 4);
    chk("l6_done", ndone, 1);
    chk("l6_short", last_short, 1);
    chk("l6_len", int'(bus.line_len_o), STAT ? 6 : 0);

    // single-pixel line
    clr();
    line(1, 1);
    chk("l1_cnt", got.size(), 0);
    chk("l1_done", ndone, 1);
    chk("l1_short", last_short, 1);

    // back-to-back lines with a single low cycle between
    clr();
    line(12, 1);
    chk_px("b2b_a", 3, 8);
    chk("b2b_a_done", ndone, 1);
    clr();
    line(12, 101);
    chk_px("b2b_b", 103, 8);
    chk("b2b_b_done", ndone, 1);
    chk("b2b_b_short", last_short, 0);
    chk("b2b_zero", zero_bad + short_bad, 0);

    // reset asserted at input pixel 5, valid held high through release
    for (int i = 1; i <= 4; i++) step(1'b1, 24'(i));
    clr();
    rst_n = 1'b0;
    step(1'b1, 24'd5);
    chk("mid_rst_dv", int'(bus.dataValid_o), 0);
    chk("mid_rst_data", int'(bus.data_o), 0);
    chk("mid_rst_done", int'(bus.line_done_o), 0);
    chk("mid_rst_len", int'(bus.line_len_o), 0);
    step(1'b1, 24'd6);
    rst_n = 1'b1;
    for (int i = 7; i <= 12; i++) step(1'b1, 24'(i));
    step(1'b0, 24'h0);
    chk("mid_cnt", got.size(), 0);
    chk("mid_done", ndone, 0);
    clr();
    line(12, 201);
    chk_px("post", 203, 8);
    chk("post_done", ndone, 1);
    chk("post_short", last_short, 0);

    // over-long line saturates the length counter
    clr();
    line(5000, 1);
    chk_px("l5k", 3, 8);
    chk("l5k_done", ndone, 1);
    chk("l5k_short", last_short, 0);
    chk("l5k_len", int'(bus.line_len_o), STAT ? 4095 : 0);
    chk("l5k_zero", zero_bad + short_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
